// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// The control-word decode helper turns a state into its Moore outputs.
package mips_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_JR        = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_I_EXEC    = 4'd12,
    ST_I_WB      = 4'd13,
    ST_ILLEGAL   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_JR = 6'h08;

  localparam logic [1:0] ALUOP_LW  = 2'b00;
  localparam logic [1:0] ALUOP_SW  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_IMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_instr;
  } ctrl_t;

  // FETCH carries ir_write/pc_write here; the top gates them with mem_ready.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic is_sw);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_LW;
        c.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALUOP_LW;
      end
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = is_sw ? ALUOP_SW : ALUOP_LW;
      end
      ST_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_R;
      end
      ST_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_op    = ALUOP_R;
      end
      ST_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_RS;
      end
      ST_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALUOP_IMM;
        c.branch    = 1'b1;
        c.pc_source = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      ST_I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_IMM;
      end
      ST_I_WB: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_IMM;
      end
      ST_ILLEGAL: c.illegal_instr = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_dispatch.sv
// DECODE-state next-state function of opcode/funct.
// I-type ALU opcodes are only accepted when IMM_ALU_EN is defined.
module mc_dispatch
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output state_t     o_next_state
);

  always_comb begin
    o_next_state = ST_ILLEGAL;
    case (i_opcode)
      OP_LW, OP_SW: o_next_state = ST_MEM_ADDR;
      OP_RTYPE: begin
        if (i_funct == FN_JR) o_next_state = ST_JR;
        else                  o_next_state = ST_R_EXEC;
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BGTZ: o_next_state = ST_BRANCH;
      OP_J: o_next_state = ST_JUMP;
`ifdef IMM_ALU_EN
      OP_ADDI, OP_ADDIU, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        o_next_state = ST_I_EXEC;
`endif
      default: o_next_state = ST_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main controller (Moore FSM, registered control word).
// Optional feature macro: IMM_ALU_EN builds the I_EXEC/I_WB path.
module mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  state_t r_state;
  state_t w_next_state;
  state_t w_dispatch;
  ctrl_t  r_ctrl;
  logic   w_fetch;

  mc_dispatch u_dispatch (
    .i_opcode     (opcode),
    .i_funct      (funct),
    .o_next_state (w_dispatch)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:      w_next_state = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) w_next_state = ST_DECODE;
        else           w_next_state = ST_FETCH;
      end
      ST_DECODE:    w_next_state = w_dispatch;
      ST_MEM_ADDR: begin
        if (opcode == OP_SW) w_next_state = ST_MEM_WRITE;
        else                 w_next_state = ST_MEM_READ;
      end
      ST_MEM_READ: begin
        if (mem_ready) w_next_state = ST_MEM_WB;
        else           w_next_state = ST_MEM_READ;
      end
      ST_MEM_WRITE: begin
        if (mem_ready) w_next_state = ST_FETCH;
        else           w_next_state = ST_MEM_WRITE;
      end
      ST_R_EXEC:    w_next_state = ST_R_WB;
      ST_MEM_WB, ST_R_WB, ST_JR, ST_BRANCH, ST_JUMP, ST_ILLEGAL:
                    w_next_state = ST_FETCH;
`ifdef IMM_ALU_EN
      ST_I_EXEC:    w_next_state = ST_I_WB;
      ST_I_WB:      w_next_state = ST_FETCH;
`endif
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Control word is decoded from the next state so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= decode_ctrl(w_next_state, opcode == OP_SW);
    end
  end

  assign w_fetch       = (r_state == ST_FETCH);
  assign ir_write      = r_ctrl.ir_write & mem_ready;
  assign pc_write      = r_ctrl.pc_write & (mem_ready | ~w_fetch);
  assign branch        = r_ctrl.branch;
  assign pc_source     = r_ctrl.pc_source;
  assign i_or_d        = r_ctrl.i_or_d;
  assign mem_read      = r_ctrl.mem_read;
  assign mem_write     = r_ctrl.mem_write;
  assign reg_dst       = r_ctrl.reg_dst;
  assign mem_to_reg    = r_ctrl.mem_to_reg;
  assign reg_write     = r_ctrl.reg_write;
  assign alu_src_a     = r_ctrl.alu_src_a;
  assign alu_src_b     = r_ctrl.alu_src_b;
  assign alu_op        = r_ctrl.alu_op;
  assign illegal_instr = r_ctrl.illegal_instr;
  assign state_o       = r_state;

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main controller for the MIPS core: a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and muxes. It also generates the 2-bit ALUOp consumed by the ALU control decoder. It sits between the instruction register (opcode/funct inputs) and the shared datapath, and stalls on a memory ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- opcode  in  6  IR[31:26], stable from the cycle after ir_write
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- branch  out  1  PC load if the datapath branch condition is true
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs (JR)
- i_or_d  out  1  0 memory address = PC, 1 memory address = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign/zero-extended imm, 11 imm<<2
- alu_op  out  2  00 add (LW), 01 add (SW), 10 R-type by funct, 11 by opcode
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode
- state_o  out  4  current state, for debug

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, JR, BRANCH, JUMP, I_EXEC, I_WB, ILLEGAL.
- Every output not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH unconditionally.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write are asserted only while mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Dispatch on opcode:
  - 0x23 or 0x2b: MEM_ADDR
  - 0x00 with funct 0x08: JR
  - 0x00 with any other funct: R_EXEC
  - 0x01, 0x04, 0x05, 0x07: BRANCH
  - 0x02: JUMP
  - 0x08, 0x09, 0x0b, 0x0c, 0x0d, 0x0e, 0x0f: I_EXEC (only under the macro)
  - anything else: ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=10. alu_op=00 for LW, 01 for SW. Next state MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_op=10. Next FETCH.
- JR: pc_write=1, pc_source=11. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=11, branch=1, pc_source=01. Next FETCH.
  - The datapath evaluates the condition from the opcode and the ALU flags.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, alu_op=11. Next FETCH.
- ILLEGAL: illegal_instr=1 for exactly one cycle. Next FETCH; the instruction is skipped and the PC is already advanced.

## Timing
- Outputs are a pure decode of the registered state (Moore). Exception: ir_write and pc_write in FETCH are ANDed with mem_ready.
- Reset: while rst_n is 0 at a clock edge, the next state is IDLE. In IDLE every output is 0 and state_o=0.
  - Reset mid-access drops mem_read/mem_write on the next cycle. The in-flight memory access is abandoned; no writeback occurs.
- Cycle counts with mem_ready held at 1, from FETCH entry:
  - LW 5
  - SW 4
  - R-type 4
  - I-type 4
  - branch 3
  - J 3
  - JR 3
  - illegal 3
- Each cycle of mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Request outputs stay stable while waiting.
- The first fetch begins 2 cycles after rst_n rises (IDLE, then FETCH).

## Configuration
- IMM_ALU_EN defined: I-type ALU opcodes (0x08, 0x09, 0x0b–0x0f) dispatch to I_EXEC/I_WB.
- IMM_ALU_EN undefined: those opcodes go to ILLEGAL and illegal_instr pulses. The I_EXEC and I_WB states are not built.

## Structure
- Shared package mips_pkg holds:
  - the state enum (4-bit)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, ...)
  - funct constant FN_JR
  - ALUOp constants (ALUOP_LW, ALUOP_SW, ALUOP_R, ALUOP_IMM)
  - pc_source and alu_src_b encodings
- One sub-module, mc_dispatch: the combinational DECODE next-state function of opcode and funct, including the IMM_ALU_EN gating.

## Test plan
- Reset low for 3 cycles, then high -> all outputs 0 in IDLE. FETCH on the 2nd cycle shows mem_read=1, alu_src_b=01.
- LW (opcode 0x23), mem_ready=1 -> state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB over 5 cycles. reg_write=1 with mem_to_reg=1 only in the last cycle.
- ADD (opcode 0x00, funct 0x20), mem_ready=0 for 2 FETCH cycles -> 6 cycles total. ir_write pulses exactly once. alu_op=10 in R_EXEC and R_WB.
- BEQ (0x04) -> 3 cycles. BRANCH state shows branch=1, pc_source=01, alu_op=11. SW with mem_ready low for 3 cycles in MEM_WRITE -> mem_write held for 4 cycles.
- ORI (0x0d) -> I_EXEC then I_WB with alu_op=11 when IMM_ALU_EN is defined. Without the macro, illegal_instr pulses 1 cycle and reg_write stays 0.
- rst_n driven 0 while in MEM_READ -> IDLE on the next edge, mem_read=0 and no reg_write. Opcode 0x3f -> ILLEGAL pulse, then FETCH.
